// File: rtl/uart_v2_rx.sv
// 8N1 UART receiver on a 4x sample clock; byte and flags land on the stop-sample edge (~38 clocks after start detect).
// No backpressure: a held byte is overwritten by the next good frame, which flags overrun_err.
module uart_v2_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 uart_sample_clk,
  input  logic                 sysreset_n,
  input  logic                 rx_line,
  input  logic                 read_ack,
  output logic [DATA_BITS-1:0] parallel_out,
  output logic                 rx_ready,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [1:0]             tick, tick_nxt;
  logic [CW-1:0]          bitcnt, bitcnt_nxt;
  logic [DATA_BITS-1:0]   shift, shift_nxt;
  logic                   load, ferr_set;

  assign rx_s = sync[SYNC_STAGES-1];

  always_ff @(posedge uart_sample_clk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      sync   <= '1;
      state  <= ST_IDLE;
      tick   <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], rx_line};
      state  <= state_nxt;
      tick   <= tick_nxt;
      bitcnt <= bitcnt_nxt;
      shift  <= shift_nxt;
    end
  end

  // Samples fall on tick 1 of START (mid start bit) and tick 3 of each later bit.
  always_comb begin
    state_nxt  = state;
    tick_nxt   = tick;
    bitcnt_nxt = bitcnt;
    shift_nxt  = shift;
    load       = 1'b0;
    ferr_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        tick_nxt = 2'd0;
        if (!rx_s) state_nxt = ST_START;
      end
      ST_START: begin
        tick_nxt = tick + 2'd1;
        if (tick == 2'd1) begin
          tick_nxt = 2'd0;
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt  = ST_DATA;
            bitcnt_nxt = '0;
          end
        end
      end
      ST_DATA: begin
        tick_nxt = tick + 2'd1;
        if (tick == 2'd3) begin
          shift_nxt  = {rx_s, shift[DATA_BITS-1:1]};
          bitcnt_nxt = bitcnt + 1'b1;
          if (bitcnt == LAST_BIT) state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        tick_nxt = tick + 2'd1;
        if (tick == 2'd3) begin
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        tick_nxt = 2'd0;
        if (rx_s) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A load on the same edge as read_ack wins; the ack only suppresses overrun.
  always_ff @(posedge uart_sample_clk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      parallel_out <= '0;
      rx_ready     <= 1'b0;
      framing_err  <= 1'b0;
      overrun_err  <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      rx_busy <= (state != ST_IDLE);
      if (load) begin
        parallel_out <= shift;
        rx_ready     <= 1'b1;
        overrun_err  <= read_ack ? 1'b0 : (overrun_err | rx_ready);
      end else if (read_ack) begin
        rx_ready    <= 1'b0;
        overrun_err <= 1'b0;
      end
      if (ferr_set) begin
        framing_err <= 1'b1;
      end else if (read_ack) begin
        framing_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_v2_rx.sv
// Directed bench for uart_v2_rx: frames driven at 4 clocks/bit, outputs sampled 1ns after the rising edge.
module tb_uart_v2_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line;
  logic       read_ack;
  logic [7:0] parallel_out;
  logic       rx_ready, framing_err, overrun_err, rx_busy;

  int total = 0;
  int bad   = 0;

  uart_v2_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .uart_sample_clk(clk),
    .sysreset_n     (rst_n),
    .rx_line        (rx_line),
    .read_ack       (read_ack),
    .parallel_out   (parallel_out),
    .rx_ready       (rx_ready),
    .framing_err    (framing_err),
    .overrun_err    (overrun_err),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start, 8 data bits LSB first, stop; each held for 4 edges. Returns 1ns after the last stop edge,
  // so the stop bit is sampled on the very next edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx_line = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      wait_clk(4);
    end
    rx_line = stop_val;
    wait_clk(4);
  endtask

  task automatic ack_pulse();
    read_ack = 1'b1;
    wait_clk(1);
    read_ack = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    rx_line  = 1'b1;
    read_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_data",  {24'd0, parallel_out}, 32'h00);
    check("rst_ready", {31'd0, rx_ready},     32'd0);
    check("rst_ferr",  {31'd0, framing_err},  32'd0);
    check("rst_oerr",  {31'd0, overrun_err},  32'd0);
    check("rst_busy",  {31'd0, rx_busy},      32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);

    // Test 1: clean 0xA5
    send_byte(8'hA5, 1'b1);
    wait_clk(1);
    check("t1_data",  {24'd0, parallel_out}, 32'hA5);
    check("t1_ready", {31'd0, rx_ready},     32'd1);
    check("t1_ferr",  {31'd0, framing_err},  32'd0);
    check("t1_oerr",  {31'd0, overrun_err},  32'd0);
    check("t1_busy_s", {31'd0, rx_busy},     32'd1);
    wait_clk(1);
    check("t1_busy_idle", {31'd0, rx_busy},  32'd0);

    // Test 2: one-clock glitch, then 0x3C
    ack_pulse();
    wait_clk(2);
    rx_line = 1'b0;
    wait_clk(1);
    rx_line = 1'b1;
    wait_clk(3);
    check("t2_busy_start", {31'd0, rx_busy}, 32'd1);
    wait_clk(2);
    check("t2_busy_abort", {31'd0, rx_busy}, 32'd0);
    check("t2_ready_glitch", {31'd0, rx_ready}, 32'd0);
    check("t2_ferr_glitch", {31'd0, framing_err}, 32'd0);
    wait_clk(2);
    send_byte(8'h3C, 1'b1);
    wait_clk(1);
    check("t2_data",  {24'd0, parallel_out}, 32'h3C);
    check("t2_ready", {31'd0, rx_ready},     32'd1);

    // Test 3: framing error on 0x55
    wait_clk(2);
    ack_pulse();
    wait_clk(2);
    send_byte(8'h55, 1'b0);
    rx_line = 1'b1;
    wait_clk(1);
    check("t3_ferr",  {31'd0, framing_err},  32'd1);
    check("t3_ready", {31'd0, rx_ready},     32'd0);
    check("t3_data",  {24'd0, parallel_out}, 32'h3C);
    check("t3_oerr",  {31'd0, overrun_err},  32'd0);
    wait_clk(4);
    check("t3_busy_after_break", {31'd0, rx_busy}, 32'd0);
    ack_pulse();
    check("t3_ferr_clr", {31'd0, framing_err}, 32'd0);

    // Test 4: back-to-back 0x41, 0x42 without ack
    wait_clk(2);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    wait_clk(1);
    check("t4_data",  {24'd0, parallel_out}, 32'h42);
    check("t4_ready", {31'd0, rx_ready},     32'd1);
    check("t4_oerr",  {31'd0, overrun_err},  32'd1);
    wait_clk(1);
    ack_pulse();
    check("t4_ready_clr", {31'd0, rx_ready},    32'd0);
    check("t4_oerr_clr",  {31'd0, overrun_err}, 32'd0);
    check("t4_ferr_clr",  {31'd0, framing_err}, 32'd0);

    // Test 5: ack coincides with 0x42 stop sample
    wait_clk(2);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    read_ack = 1'b1;
    wait_clk(1);
    read_ack = 1'b0;
    check("t5_data",  {24'd0, parallel_out}, 32'h42);
    check("t5_ready", {31'd0, rx_ready},     32'd1);
    check("t5_oerr",  {31'd0, overrun_err},  32'd0);

    // Test 6: reset during data bit 4 of 0xFF, then 0x81
    wait_clk(2);
    rx_line = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 4; i++) begin
      rx_line = 1'b1;
      wait_clk(4);
    end
    rx_line = 1'b1;
    wait_clk(2);
    check("t6_busy_mid", {31'd0, rx_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_data",  {24'd0, parallel_out}, 32'h00);
    check("t6_rst_ready", {31'd0, rx_ready},     32'd0);
    check("t6_rst_ferr",  {31'd0, framing_err},  32'd0);
    check("t6_rst_oerr",  {31'd0, overrun_err},  32'd0);
    check("t6_rst_busy",  {31'd0, rx_busy},      32'd0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    send_byte(8'h81, 1'b1);
    wait_clk(1);
    check("t6_data",  {24'd0, parallel_out}, 32'h81);
    check("t6_ready", {31'd0, rx_ready},     32'd1);
    check("t6_ferr",  {31'd0, framing_err},  32'd0);
    check("t6_oerr",  {31'd0, overrun_err},  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
